// File: rtl/spike_packet_tx_pkg.sv
// Shared definitions for the spike injection transmitter: packet field
// positions, the packed packet layout and the drain FSM states.
package spike_packet_tx_pkg;

  localparam int PACKET_WIDTH = 30;
  localparam int DX_MSB       = 29;
  localparam int DX_LSB       = 21;
  localparam int DY_MSB       = 20;
  localparam int DY_LSB       = 12;
  localparam int AXON_W       = 8;
  localparam int TICK_W       = 4;
  localparam int QUEUE_DEPTH  = 4;

  localparam int DX_W = DX_MSB - DX_LSB + 1;
  localparam int DY_W = DY_MSB - DY_LSB + 1;

  // Field order matches the router's packet layout from MSB down to bit 0.
  typedef struct packed {
    logic [DX_W-1:0]   dx;
    logic [DY_W-1:0]   dy;
    logic [TICK_W-1:0] tick_offset;
    logic [AXON_W-1:0] axon;
  } packet_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/spike_tx_fifo.sv
// Generic synchronous circular FIFO. Head is combinational and reads as zero
// when empty. Push and pop together keep the count, even when full.
module spike_tx_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/spike_packet_tx.sv
// Local injection transmitter: packs spike events, queues them, feeds the
// router under backpressure and signals end-of-tick drain completion.
// Optional per-tick packet statistics are built when SPIKE_TX_STATS_EN is defined.
module spike_packet_tx
  import spike_packet_tx_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spike_valid,
  output logic                    spike_ready,
  input  logic [DX_W-1:0]         spike_dx,
  input  logic [DY_W-1:0]         spike_dy,
  input  logic [TICK_W-1:0]       spike_tick_offset,
  input  logic [AXON_W-1:0]       spike_axon,
  input  logic                    tick,
  input  logic                    local_buffers_full,
  output logic [PACKET_WIDTH-1:0] dout,
  output logic                    dout_wen,
  output logic                    drained,
  output logic [15:0]             sent_count
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

  state_t          state;
  state_t          state_next;
  packet_t         pkt;
  logic            push;
  logic [CW-1:0]   count;

  assign pkt = '{dx: spike_dx, dy: spike_dy,
                 tick_offset: spike_tick_offset, axon: spike_axon};

  assign spike_ready = (state == RUN) && (count < FULL_COUNT);
  assign push        = spike_valid && spike_ready;
  assign dout_wen    = (count != '0) && !local_buffers_full;

  spike_tx_fifo #(
    .WIDTH (PACKET_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (dout_wen),
    .din   (pkt),
    .head  (dout),
    .count (count)
  );

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and drain-complete pulse; the last pop of a drain completes it.
  always_comb begin
    state_next = state;
    drained    = 1'b0;
    case (state)
      RUN: begin
        if (tick) state_next = DRAIN;
      end
      DRAIN: begin
        if ((count == '0) || ((count == ONE_COUNT) && dout_wen)) begin
          state_next = RUN;
          drained    = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

`ifdef SPIKE_TX_STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] pkt_count_next;

  // Saturating count of injected packets, including this cycle's pop.
  always_comb begin
    pkt_count_next = pkt_count;
    if (dout_wen && (pkt_count != 16'hFFFF)) begin
      pkt_count_next = pkt_count + 16'd1;
    end
  end

  // Publish the tick's total on the drain pulse and start the next tick at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count  <= '0;
      sent_count <= '0;
    end else if (drained) begin
      pkt_count  <= '0;
      sent_count <= pkt_count_next;
    end else begin
      pkt_count  <= pkt_count_next;
    end
  end
`else
  assign sent_count = '0;
`endif

endmodule
